midi_msg_sequencer: RTL and testbench

Assembles raw MIDI bytes into complete channel messages for the synth controller. Drives `cur_status` into the registered `midi_status` decoder, waits out its pipeline latency, and latches the decoded flags. Collects data bytes with running-status support and emits one-cycle message strobes. SysEx payload bytes are forwarded as a separate stream.

---
 rtl/midi_msg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_midi_msg_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_sequencer.sv
// MIDI byte-stream sequencer: drives a registered status decoder, latches its flags and
// assembles channel messages (running status, real-time interleave, SysEx passthrough).
module midi_msg_sequencer #(
   parameter int unsigned DEC_LAT = 2
) (
   input  logic       reg_clk,
   input  logic       reset_reg_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] cur_status,
   input  logic       is_cur_midi_ch,
   input  logic       is_st_note_on,
   input  logic       is_st_note_off,
   input  logic       is_st_ctrl,
   input  logic       is_st_prg_change,
   input  logic       is_st_pitch,
   input  logic       is_st_sysex,
   output logic       msg_valid,
   output logic [2:0] msg_type,
   output logic [6:0] msg_data1,
   output logic [6:0] msg_data2,
   output logic       msg_drop,
   output logic       sysex_active,
   output logic       sysex_valid
);

   localparam int unsigned CntW = (DEC_LAT > 0) ? $clog2(DEC_LAT + 1) : 1;

   // Latched flag vector layout
   localparam int unsigned FlMidiCh  = 0;
   localparam int unsigned FlNoteOn  = 1;
   localparam int unsigned FlNoteOff = 2;
   localparam int unsigned FlCtrl    = 3;
   localparam int unsigned FlPrg     = 4;
   localparam int unsigned FlPitch   = 5;
   localparam int unsigned FlSysex   = 6;

   typedef enum logic [2:0] {StIdle, StDecode, StData1, StData2, StSysex} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        cur_status_q, cur_status_d;
   logic              run_valid_q, run_valid_d;
   logic [6:0]        flags_q, flags_d;
   logic [6:0]        data1_q, data1_d;
   logic [2:0]        msg_type_q, msg_type_d;
   logic [6:0]        msg_data1_q, msg_data1_d;
   logic [6:0]        msg_data2_q, msg_data2_d;
   logic              msg_valid_q, msg_valid_d;
   logic              msg_drop_q, msg_drop_d;
   logic              sysex_valid_q, sysex_valid_d;

   logic              accept;
   logic              is_rt;
   logic              one_byte;
   logic              msg_ok;
   logic              finish;
   logic [6:0]        fin_d1, fin_d2;
   logic [6:0]        dec_flags;

   assign dec_flags = {is_st_sysex, is_st_pitch, is_st_prg_change, is_st_ctrl,
                       is_st_note_off, is_st_note_on, is_cur_midi_ch};

   assign byte_ready = (state_q != StDecode);
   assign accept     = byte_valid & byte_ready;
   assign is_rt      = (byte_in[7:3] == 5'b11111);
   assign one_byte   = (cur_status_q[6:5] == 2'b10);

   // Poly aftertouch (A0) and channel pressure (D0) are never forwarded; a sysex flag on a
   // channel status means the decoder disagrees with us, so that is dropped as well.
   assign msg_ok = flags_q[FlMidiCh] && !flags_q[FlSysex] &&
                   (flags_q[FlNoteOn] || flags_q[FlNoteOff] || flags_q[FlCtrl] ||
                    flags_q[FlPrg] || flags_q[FlPitch]) &&
                   (cur_status_q[6:4] != 3'b010) && (cur_status_q[6:4] != 3'b101);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cur_status_d  = cur_status_q;
      run_valid_d   = run_valid_q;
      flags_d       = flags_q;
      data1_d       = data1_q;
      msg_type_d    = msg_type_q;
      msg_data1_d   = msg_data1_q;
      msg_data2_d   = msg_data2_q;
      msg_valid_d   = 1'b0;
      msg_drop_d    = 1'b0;
      sysex_valid_d = 1'b0;
      finish        = 1'b0;
      fin_d1        = data1_q;
      fin_d2        = 7'h00;

      if (state_q == StDecode) begin
         if (cnt_q == '0) begin
            flags_d = dec_flags;
            if (is_st_sysex && (cur_status_q == 8'hF0)) begin
               state_d     = StSysex;
               run_valid_d = 1'b0;
            end else if (cur_status_q[7:4] == 4'hF) begin
               state_d     = StIdle;
               run_valid_d = 1'b0;
            end else begin
               state_d     = StData1;
               run_valid_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end else if (accept && !is_rt) begin
         if (byte_in[7]) begin
            cur_status_d = byte_in;
            msg_drop_d   = (state_q == StData1) || (state_q == StData2);
            if ((state_q == StSysex) && (byte_in == 8'hF7)) begin
               state_d     = StIdle;
               run_valid_d = 1'b0;
            end else begin
               state_d = StDecode;
               cnt_d   = CntW'(DEC_LAT);
            end
         end else begin
            case (state_q)
               StIdle, StData1: begin
                  // In IDLE a data byte only counts under a valid running status
                  if ((state_q == StData1) || run_valid_q) begin
                     if (one_byte) begin
                        finish  = 1'b1;
                        fin_d1  = byte_in[6:0];
                        state_d = StIdle;
                     end else begin
                        data1_d = byte_in[6:0];
                        state_d = StData2;
                     end
                  end
               end
               StData2: begin
                  finish  = 1'b1;
                  fin_d2  = byte_in[6:0];
                  state_d = StIdle;
               end
               StSysex: begin
                  msg_data1_d   = byte_in[6:0];
                  sysex_valid_d = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (finish) begin
         if (msg_ok) begin
            msg_valid_d = 1'b1;
            msg_data1_d = fin_d1;
            msg_data2_d = fin_d2;
            if (flags_q[FlNoteOff]) begin
               msg_type_d = 3'd0;
            end else if (flags_q[FlNoteOn]) begin
               msg_type_d = (fin_d2 == 7'h00) ? 3'd0 : 3'd1;
            end else if (flags_q[FlCtrl]) begin
               msg_type_d = 3'd2;
            end else if (flags_q[FlPrg]) begin
               msg_type_d = 3'd3;
            end else begin
               msg_type_d = 3'd4;
            end
         end else begin
            msg_drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge reg_clk or negedge reset_reg_n) begin
      if (!reset_reg_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         cur_status_q  <= 8'h00;
         run_valid_q   <= 1'b0;
         flags_q       <= '0;
         data1_q       <= '0;
         msg_type_q    <= '0;
         msg_data1_q   <= '0;
         msg_data2_q   <= '0;
         msg_valid_q   <= 1'b0;
         msg_drop_q    <= 1'b0;
         sysex_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cur_status_q  <= cur_status_d;
         run_valid_q   <= run_valid_d;
         flags_q       <= flags_d;
         data1_q       <= data1_d;
         msg_type_q    <= msg_type_d;
         msg_data1_q   <= msg_data1_d;
         msg_data2_q   <= msg_data2_d;
         msg_valid_q   <= msg_valid_d;
         msg_drop_q    <= msg_drop_d;
         sysex_valid_q <= sysex_valid_d;
      end
   end

   assign cur_status   = cur_status_q;
   assign msg_valid    = msg_valid_q;
   assign msg_type     = msg_type_q;
   assign msg_data1    = msg_data1_q;
   assign msg_data2    = msg_data2_q;
   assign msg_drop     = msg_drop_q;
   assign sysex_valid  = sysex_valid_q;
   assign sysex_active = (state_q == StSysex);

endmodule

// File: tb/tb_midi_msg_sequencer.sv
// Directed bench for midi_msg_sequencer with a two-stage registered model of the status decoder.
module tb_midi_msg_sequencer;

   logic       reg_clk;
   logic       reset_reg_n;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] cur_status;
   logic       is_cur_midi_ch, is_st_note_on, is_st_note_off, is_st_ctrl;
   logic       is_st_prg_change, is_st_pitch, is_st_sysex;
   logic       msg_valid;
   logic [2:0] msg_type;
   logic [6:0] msg_data1, msg_data2;
   logic       msg_drop, sysex_active, sysex_valid;

   int         n_checks;
   int         n_fail;
   logic [3:0] tb_channel;
   logic [6:0] dec_s1, dec_s2;

   midi_msg_sequencer #(.DEC_LAT(2)) dut (
      .reg_clk         (reg_clk),
      .reset_reg_n     (reset_reg_n),
      .byte_in         (byte_in),
      .byte_valid      (byte_valid),
      .byte_ready      (byte_ready),
      .cur_status      (cur_status),
      .is_cur_midi_ch  (is_cur_midi_ch),
      .is_st_note_on   (is_st_note_on),
      .is_st_note_off  (is_st_note_off),
      .is_st_ctrl      (is_st_ctrl),
      .is_st_prg_change(is_st_prg_change),
      .is_st_pitch     (is_st_pitch),
      .is_st_sysex     (is_st_sysex),
      .msg_valid       (msg_valid),
      .msg_type        (msg_type),
      .msg_data1       (msg_data1),
      .msg_data2       (msg_data2),
      .msg_drop        (msg_drop),
      .sysex_active    (sysex_active),
      .sysex_valid     (sysex_valid)
   );

   initial reg_clk = 1'b0;
   always #5 reg_clk = ~reg_clk;

   // Flag order: {sysex, pitch, prg, ctrl, note_off, note_on, midi_ch}
   function automatic logic [6:0] decode(input logic [7:0] st, input logic [3:0] ch);
      logic [6:0] f;
      f    = '0;
      f[0] = st[7] && (st[7:4] != 4'hF) && (st[3:0] == ch);
      f[1] = (st[7:4] == 4'h9);
      f[2] = (st[7:4] == 4'h8);
      f[3] = (st[7:4] == 4'hB);
      f[4] = (st[7:4] == 4'hC);
      f[5] = (st[7:4] == 4'hE);
      f[6] = (st == 8'hF0);
      return f;
   endfunction

   always @(posedge reg_clk or negedge reset_reg_n) begin
      if (!reset_reg_n) begin
         dec_s1 <= '0;
         dec_s2 <= '0;
      end else begin
         dec_s1 <= decode(cur_status, tb_channel);
         dec_s2 <= dec_s1;
      end
   end

   assign {is_st_sysex, is_st_pitch, is_st_prg_change, is_st_ctrl,
           is_st_note_off, is_st_note_on, is_cur_midi_ch} = dec_s2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a byte, wait (bounded) for byte_ready, return #1 after the accept edge
   task automatic send(input logic [7:0] b);
      int waited;
      waited     = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge reg_clk);
      while (!byte_ready && waited < 20) begin
         @(negedge reg_clk);
         waited++;
      end
      check("accept_within_bound", {31'b0, byte_ready}, 32'd1);
      @(posedge reg_clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge reg_clk);
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      tb_channel  = 4'h1;
      reset_reg_n = 1'b0;
      byte_in     = 8'h00;
      byte_valid  = 1'b0;
      repeat (3) @(posedge reg_clk);
      #1;
      check("rst_byte_ready", {31'b0, byte_ready}, 32'd1);
      check("rst_cur_status", {24'b0, cur_status}, 32'h00);
      check("rst_msg_valid", {31'b0, msg_valid}, 32'd0);
      check("rst_msg_drop", {31'b0, msg_drop}, 32'd0);
      check("rst_sysex_active", {31'b0, sysex_active}, 32'd0);
      check("rst_msg_type", {29'b0, msg_type}, 32'd0);
      reset_reg_n = 1'b1;
      tick();

      // Note-on on our channel, decode wait is three cycles of byte_ready low
      send(8'h91);
      check("t1_cur_status", {24'b0, cur_status}, 32'h91);
      check("t1_ready_e0", {31'b0, byte_ready}, 32'd0);
      tick();
      check("t1_ready_e1", {31'b0, byte_ready}, 32'd0);
      tick();
      check("t1_ready_e2", {31'b0, byte_ready}, 32'd0);
      tick();
      check("t1_ready_e3", {31'b0, byte_ready}, 32'd1);
      send(8'h3C);
      check("t1_no_early_valid", {31'b0, msg_valid}, 32'd0);
      send(8'h64);
      check("t1_valid", {31'b0, msg_valid}, 32'd1);
      check("t1_type", {29'b0, msg_type}, 32'd1);
      check("t1_data1", {25'b0, msg_data1}, 32'h3C);
      check("t1_data2", {25'b0, msg_data2}, 32'h64);
      tick();
      check("t1_valid_one_cycle", {31'b0, msg_valid}, 32'd0);

      // Running status, note-on velocity 0 reported as note-off
      send(8'h40);
      check("t2_no_decode", {31'b0, byte_ready}, 32'd1);
      send(8'h00);
      check("t2_valid", {31'b0, msg_valid}, 32'd1);
      check("t2_type", {29'b0, msg_type}, 32'd0);
      check("t2_data1", {25'b0, msg_data1}, 32'h40);
      check("t2_data2", {25'b0, msg_data2}, 32'h00);

      // Foreign channel control change
      send(8'hB5);
      send(8'h07);
      send(8'h7F);
      check("t3_drop", {31'b0, msg_drop}, 32'd1);
      check("t3_no_valid", {31'b0, msg_valid}, 32'd0);
      check("t3_hold_data1", {25'b0, msg_data1}, 32'h40);
      tick();
      check("t3_drop_one_cycle", {31'b0, msg_drop}, 32'd0);

      // Program change with an interleaved clock byte
      tb_channel = 4'h0;
      send(8'hC0);
      send(8'hF8);
      check("t4_rt_no_valid", {31'b0, msg_valid}, 32'd0);
      send(8'h05);
      check("t4_valid", {31'b0, msg_valid}, 32'd1);
      check("t4_type", {29'b0, msg_type}, 32'd3);
      check("t4_data1", {25'b0, msg_data1}, 32'h05);
      check("t4_data2", {25'b0, msg_data2}, 32'h00);
      // Channel change does not affect running-status messages
      tb_channel = 4'h5;
      send(8'h06);
      check("t4_rs_valid", {31'b0, msg_valid}, 32'd1);
      check("t4_rs_data1", {25'b0, msg_data1}, 32'h06);

      // SysEx passthrough
      send(8'hF0);
      check("t5_not_yet_active", {31'b0, sysex_active}, 32'd0);
      send(8'h43);
      check("t5_active", {31'b0, sysex_active}, 32'd1);
      check("t5_sx_valid_a", {31'b0, sysex_valid}, 32'd1);
      check("t5_sx_data_a", {25'b0, msg_data1}, 32'h43);
      send(8'h10);
      check("t5_sx_valid_b", {31'b0, sysex_valid}, 32'd1);
      check("t5_sx_data_b", {25'b0, msg_data1}, 32'h10);
      send(8'hF7);
      check("t5_inactive", {31'b0, sysex_active}, 32'd0);
      check("t5_sx_valid_end", {31'b0, sysex_valid}, 32'd0);
      check("t5_ready_after_f7", {31'b0, byte_ready}, 32'd1);
      send(8'h22);
      check("t5_trail_no_valid", {31'b0, msg_valid}, 32'd0);
      check("t5_trail_no_drop", {31'b0, msg_drop}, 32'd0);
      check("t5_trail_no_sx", {31'b0, sysex_valid}, 32'd0);

      // Abort a note with a new status, then reset in the middle of DATA2
      tb_channel = 4'h0;
      send(8'h90);
      send(8'h3C);
      send(8'hB0);
      check("t6_abort_drop", {31'b0, msg_drop}, 32'd1);
      check("t6_abort_no_valid", {31'b0, msg_valid}, 32'd0);
      check("t6_decode", {31'b0, byte_ready}, 32'd0);
      check("t6_cur_status", {24'b0, cur_status}, 32'hB0);
      send(8'h07);
      reset_reg_n = 1'b0;
      #2;
      check("t6_rst_ready", {31'b0, byte_ready}, 32'd1);
      check("t6_rst_cur_status", {24'b0, cur_status}, 32'h00);
      check("t6_rst_type", {29'b0, msg_type}, 32'd0);
      check("t6_rst_data1", {25'b0, msg_data1}, 32'h00);
      check("t6_rst_valid", {31'b0, msg_valid}, 32'd0);
      check("t6_rst_drop", {31'b0, msg_drop}, 32'd0);
      tick();
      reset_reg_n = 1'b1;
      tick();

      // Reset while inside SysEx clears sysex_active without a clock edge
      send(8'hF0);
      send(8'h01);
      check("t7_active", {31'b0, sysex_active}, 32'd1);
      reset_reg_n = 1'b0;
      #1;
      check("t7_async_clear", {31'b0, sysex_active}, 32'd0);
      check("t7_async_sx_valid", {31'b0, sysex_valid}, 32'd0);
      tick();
      reset_reg_n = 1'b1;
      tick();

      // Running status is gone after reset; then a pitch bend
      send(8'h11);
      check("t8_discard_valid", {31'b0, msg_valid}, 32'd0);
      check("t8_discard_drop", {31'b0, msg_drop}, 32'd0);
      tb_channel = 4'h1;
      send(8'hE1);
      send(8'h00);
      send(8'h40);
      check("t8_pitch_valid", {31'b0, msg_valid}, 32'd1);
      check("t8_pitch_type", {29'b0, msg_type}, 32'd4);
      check("t8_pitch_data1", {25'b0, msg_data1}, 32'h00);
      check("t8_pitch_data2", {25'b0, msg_data2}, 32'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
